regbank_mp: RTL and testbench
=============================

Name: regbank_mp

Overview:
Parametrised multi-port register bank, the successor to the single-write, two-read integer register file.
- Generalised in data width, register count, read-port count and write-port count.
- Adds optional same-cycle write-to-read bypass.
- Adds a per-register pending-write scoreboard, so the issue stage can stall on RAW hazards.
- Sits between decode/issue (read, reserve) and writeback (write, release). Register 0 is hardwired to zero.

Parameters:
DATA_W, 32, data width of each register
NREGS, 32, number of architectural registers incl. hardwired register 0; power of two, >= 2
NRD, 2, number of read ports
NWR, 1, number of write ports
BYPASS, 1, 1 = read returns the same-cycle write data; 0 = read returns the stored value
AW (localparam), $clog2(NREGS), address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
rd_addr  in  NRD x AW  read addresses, packed array [NRD-1:0][AW-1:0]
rd_data  out  NRD x DATA_W  read data per port
rd_busy  out  NRD  scoreboard pending bit of the addressed register
wr_en  in  NWR  write enables
wr_addr  in  NWR x AW  write addresses
wr_data  in  NWR x DATA_W  write data
rsv_en  in  1  reserve (mark pending) request from issue
rsv_addr  in  AW  register to reserve
busy_vec  out  NREGS  full scoreboard; bit 0 is always 0

Behaviour:
- Reset (reset=0, async):
  - all registers clear to 0; all scoreboard bits clear to 0.
  - rd_data and rd_busy follow combinationally from the cleared state, so they read 0.
  - Writes and reservations are ignored while reset is low.
- Reads: combinational, zero latency, all NRD ports independent.
  - Address 0 always returns 0 and busy 0.
- Writes: take effect on the rising clk edge when wr_en[k]=1 and wr_addr[k]!=0.
  - Writes to address 0 are discarded.
- Write-write conflict: several enabled ports with the same nonzero address in one cycle → the highest port index wins; the others are dropped.
- Bypass (BYPASS=1): if a read address equals an enabled nonzero write address in the same cycle, rd_data returns that write data (highest-index matching port), not the stored value.
- No bypass (BYPASS=0): rd_data returns the pre-edge stored value; the new value is visible the next cycle.
- Scoreboard:
  - rsv_en=1 with rsv_addr!=0 sets busy[rsv_addr] at the clk edge.
  - Any enabled write to a nonzero address clears that register's busy bit at the clk edge.
  - Reserve and write to the same register in the same cycle → set wins; the new reservation supersedes the retiring writer, and busy stays 1.
  - Reserving an already-busy register: it stays busy (no counting).
  - A write to a non-busy register is legal and leaves busy at 0.
- rd_busy[i] = busy[rd_addr[i]] as registered; it is not bypassed by same-cycle writes or reservations.
- busy_vec[0] is tied to 0.
- Reset asserted mid-operation: state clears immediately, independent of clk; pending writes in that cycle are lost.
- Width rules:
  - No arithmetic in the block.
  - Addresses are compared at full AW; no out-of-range addresses exist because NREGS is a power of two.
- Implementation: the read mux is a plain indexed select or priority mux; tri-state or multiply-driven nets are not permitted.

Decomposition:
- Shared package regbank_pkg:
  - default DATA_W / NREGS constants;
  - ZERO_REG address constant (0);
  - typedef reg_addr_t (logic [AW-1:0]) and reg_data_t (logic [DATA_W-1:0]).
- One natural sub-module, regbank_sb: the scoreboard (busy bits, set/clear priority, busy_vec).
  - Instantiated once; the data array and read/bypass muxes stay in regbank_mp.

Test Plan:
- Reset, then read all addresses on both ports → rd_data=0, rd_busy=0, busy_vec=0.
- NWR=2, same cycle: wr0 addr 5 data 0x1111_1111 and wr1 addr 5 data 0x2222_2222; next cycle read 5 → 0x2222_2222.
- BYPASS=1: write addr 7 data 0xDEAD_BEEF while rd_addr[0]=7 → rd_data[0]=0xDEAD_BEEF in the same cycle. BYPASS=0, same stimulus → old value 0 in that cycle, 0xDEAD_BEEF the next cycle.
- Write addr 0 data 0xFFFF_FFFF and rsv addr 0 → read 0 returns 0, busy_vec[0]=0.
- Scoreboard sequence:
  - rsv addr 3 → busy_vec[3]=1 and rd_busy=1 for rd_addr=3, next cycle;
  - rsv 3 together with a write to 3 → still 1;
  - write 3 alone → busy_vec[3]=0.
- Write addr 9 data 0xA5A5_A5A5 and rsv 9, then drop reset mid-cycle (async, no clk edge) → rd_data=0, busy_vec=0 immediately; state stays cleared after reset is released.

Source files
------------

// File: rtl/regbank_pkg.sv
// -----------------------------------------------------------------------------
// regbank_pkg
// Shared constants and types for the multi-port register bank.
//   DEF_DATA_W / DEF_NREGS : default register width and register count
//   DEF_AW                 : address width for the default register count
//   ZERO_REG               : address of the hardwired-zero register
//   reg_addr_t / reg_data_t: address and data types at the default sizes
// -----------------------------------------------------------------------------
package regbank_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREGS  = 32;
    localparam int DEF_AW     = $clog2(DEF_NREGS);
    localparam int ZERO_REG   = 0;

    typedef logic [DEF_AW-1:0]     reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage : regbank_pkg

// File: rtl/regbank_sb.sv
// -----------------------------------------------------------------------------
// regbank_sb
// Pending-write scoreboard: one busy bit per architectural register.
// Issue reserves a register (sets its bit); writeback retires it (clears it).
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   wr_en     in   [NWR]        write enables from writeback
//   wr_addr   in   [NWR][AW]    write addresses
//   rsv_en    in   reserve request from issue
//   rsv_addr  in   [AW]         register to reserve
//   busy_vec  out  [NREGS]      registered busy bits, bit 0 always 0
// -----------------------------------------------------------------------------
module regbank_sb
    import regbank_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NWR-1:0]         wr_en,
    input  logic [NWR-1:0][AW-1:0] wr_addr,
    input  logic                   rsv_en,
    input  logic [AW-1:0]          rsv_addr,
    output logic [NREGS-1:0]       busy_vec
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Clears are applied first and the reservation last, so a reserve and a
    // retiring write to the same register leave it busy: the new reservation
    // belongs to a younger instruction than the writer.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int k = 0; k < NWR; k++) begin
            if (wr_en[k] && (wr_addr[k] != AW'(ZERO_REG))) begin
                w_busy_nxt[wr_addr[k]] = 1'b0;
            end
        end
        if (rsv_en && (rsv_addr != AW'(ZERO_REG))) begin
            w_busy_nxt[rsv_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_vec = r_busy;

endmodule : regbank_sb

// File: rtl/regbank_mp.sv
// -----------------------------------------------------------------------------
// regbank_mp
// Parametrised multi-port register bank with optional write-to-read bypass
// and a pending-write scoreboard. Register 0 is hardwired to zero.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   rd_addr   in   [NRD][AW]      read addresses
//   rd_data   out  [NRD][DATA_W]  combinational read data
//   rd_busy   out  [NRD]          busy bit of each addressed register
//   wr_en     in   [NWR]          write enables
//   wr_addr   in   [NWR][AW]      write addresses
//   wr_data   in   [NWR][DATA_W]  write data
//   rsv_en    in   reserve request
//   rsv_addr  in   [AW]           register to reserve
//   busy_vec  out  [NREGS]        full scoreboard, bit 0 always 0
// -----------------------------------------------------------------------------
module regbank_mp
    import regbank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NRD-1:0][AW-1:0]     rd_addr,
    output logic [NRD-1:0][DATA_W-1:0] rd_data,
    output logic [NRD-1:0]             rd_busy,
    input  logic [NWR-1:0]             wr_en,
    input  logic [NWR-1:0][AW-1:0]     wr_addr,
    input  logic [NWR-1:0][DATA_W-1:0] wr_data,
    input  logic                       rsv_en,
    input  logic [AW-1:0]              rsv_addr,
    output logic [NREGS-1:0]           busy_vec
);

    logic [DATA_W-1:0] r_mem [NREGS];
    logic [NREGS-1:0]  w_busy_vec;

    regbank_sb #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_vec (w_busy_vec)
    );

    // Ports are visited in ascending order, so the highest-index port that
    // targets a register is the last assignment and wins the conflict.
    // Entry 0 is never written; reads of address 0 are forced to zero below.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k] != AW'(ZERO_REG))) begin
                    r_mem[wr_addr[k]] <= wr_data[k];
                end
            end
        end
    end

    // Bypass is suppressed while reset is low: writes are ignored then, so
    // the read must reflect the cleared array rather than in-flight data.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (rd_addr[i] != AW'(ZERO_REG)) begin
                rd_data[i] = r_mem[rd_addr[i]];
                if ((BYPASS != 0) && reset) begin
                    for (int k = 0; k < NWR; k++) begin
                        if (wr_en[k] && (wr_addr[k] == rd_addr[i])) begin
                            rd_data[i] = wr_data[k];
                        end
                    end
                end
            end
            rd_busy[i] = w_busy_vec[rd_addr[i]];
        end
    end

    assign busy_vec = w_busy_vec;

endmodule : regbank_mp

// File: tb/tb_regbank_mp.sv
module tb_regbank_mp;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic                  clk;
    logic                  reset;
    logic [1:0][AW-1:0]    rd_addr;
    logic [1:0]            wr_en;
    logic [1:0][AW-1:0]    wr_addr;
    logic [1:0][DW-1:0]    wr_data;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_addr;

    logic [1:0][DW-1:0]    b_rd_data, n_rd_data;
    logic [1:0]            b_rd_busy, n_rd_busy;
    logic [NR-1:0]         b_busy_vec, n_busy_vec;

    regbank_mp #(.DATA_W(DW), .NREGS(NR), .NRD(2), .NWR(2), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(b_busy_vec)
    );

    regbank_mp #(.DATA_W(DW), .NREGS(NR), .NRD(2), .NWR(2), .BYPASS(0)) u_nob (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(n_rd_data),
        .rd_busy(n_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(n_busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: architectural register contents and pending bits.
    logic [DW-1:0] m_mem  [NR];
    bit            m_busy [NR];

    typedef struct {
        logic [1:0]    wen;
        logic [AW-1:0] wa0;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd0;
        logic [DW-1:0] wd1;
        logic          rsv;
        logic [AW-1:0] rsva;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] b0;
        logic [DW-1:0] b1;
        logic [DW-1:0] n0;
        logic [DW-1:0] n1;
        logic [1:0]    busy;
        logic [DW-1:0] bvec;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic drive(input logic [1:0] wen, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                         input logic [DW-1:0] wd0, input logic [DW-1:0] wd1, input logic rsv,
                         input logic [AW-1:0] rsva, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        wr_en      = wen;
        wr_addr[0] = wa0;
        wr_addr[1] = wa1;
        wr_data[0] = wd0;
        wr_data[1] = wd1;
        rsv_en     = rsv;
        rsv_addr   = rsva;
        rd_addr[0] = ra0;
        rd_addr[1] = ra1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // One clock edge of the architectural behaviour.
    task automatic model_clock();
        for (int k = 0; k < 2; k++) begin
            if (wr_en[k] && wr_addr[k] != 0) begin
                m_mem[wr_addr[k]]  = wr_data[k];
                m_busy[wr_addr[k]] = 1'b0;
            end
        end
        if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    endtask

    function automatic logic [DW-1:0] exp_rd(input int p, input bit byp);
        logic [AW-1:0] a;
        a = rd_addr[p];
        if (a == 0) return '0;
        if (byp) begin
            if (wr_en[1] && wr_addr[1] == a) return wr_data[1];
            if (wr_en[0] && wr_addr[0] == a) return wr_data[0];
        end
        return m_mem[a];
    endfunction

    function automatic logic [DW-1:0] exp_bvec();
        logic [DW-1:0] v;
        v = '0;
        for (int i = 1; i < NR; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic check_model(input string tag);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("%s byp rd_data[%0d]", tag, p), b_rd_data[p], exp_rd(p, 1'b1));
            chk($sformatf("%s nob rd_data[%0d]", tag, p), n_rd_data[p], exp_rd(p, 1'b0));
            chk($sformatf("%s byp rd_busy[%0d]", tag, p), DW'(b_rd_busy[p]), DW'(m_busy[rd_addr[p]]));
            chk($sformatf("%s nob rd_busy[%0d]", tag, p), DW'(n_rd_busy[p]), DW'(m_busy[rd_addr[p]]));
        end
        chk({tag, " byp busy_vec"}, b_busy_vec, exp_bvec());
        chk({tag, " nob busy_vec"}, n_busy_vec, exp_bvec());
    endtask

    task automatic check_zero(input string tag);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("%s byp rd_data[%0d]", tag, p), b_rd_data[p], '0);
            chk($sformatf("%s nob rd_data[%0d]", tag, p), n_rd_data[p], '0);
        end
        chk({tag, " byp rd_busy"}, DW'(b_rd_busy), '0);
        chk({tag, " nob rd_busy"}, DW'(n_rd_busy), '0);
        chk({tag, " byp busy_vec"}, b_busy_vec, '0);
        chk({tag, " nob busy_vec"}, n_busy_vec, '0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //          wen    wa0 wa1 wd0           wd1           rsv  rsva ra0 ra1 b0            b1            n0            n1            busy   bvec
        tbl[0] = '{2'b11, 5,  5,  32'h1111_1111, 32'h2222_2222, 1'b0, 0, 5,  5,  32'h2222_2222, 32'h2222_2222, 32'h0,         32'h0,         2'b00, 32'h0};
        tbl[1] = '{2'b00, 0,  0,  32'h0,         32'h0,         1'b0, 0, 5,  7,  32'h2222_2222, 32'h0,         32'h2222_2222, 32'h0,         2'b00, 32'h0};
        tbl[2] = '{2'b01, 7,  0,  32'hDEAD_BEEF, 32'h0,         1'b0, 0, 7,  5,  32'hDEAD_BEEF, 32'h2222_2222, 32'h0,         32'h2222_2222, 2'b00, 32'h0};
        tbl[3] = '{2'b00, 0,  0,  32'h0,         32'h0,         1'b0, 0, 7,  0,  32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 32'h0,         2'b00, 32'h0};
        tbl[4] = '{2'b01, 0,  0,  32'hFFFF_FFFF, 32'h0,         1'b1, 0, 0,  0,  32'h0,         32'h0,         32'h0,         32'h0,         2'b00, 32'h0};
        tbl[5] = '{2'b00, 0,  0,  32'h0,         32'h0,         1'b0, 0, 0,  5,  32'h0,         32'h2222_2222, 32'h0,         32'h2222_2222, 2'b00, 32'h0};
        tbl[6] = '{2'b00, 0,  0,  32'h0,         32'h0,         1'b1, 3, 3,  5,  32'h0,         32'h2222_2222, 32'h0,         32'h2222_2222, 2'b00, 32'h0};
        tbl[7] = '{2'b10, 0,  3,  32'h0,         32'h33,        1'b1, 3, 3,  3,  32'h33,        32'h33,        32'h0,         32'h0,         2'b11, 32'h8};
        tbl[8] = '{2'b01, 3,  0,  32'h44,        32'h0,         1'b0, 0, 3,  7,  32'h44,        32'hDEAD_BEEF, 32'h33,        32'hDEAD_BEEF, 2'b01, 32'h8};
        tbl[9] = '{2'b00, 0,  0,  32'h0,         32'h0,         1'b0, 0, 3,  3,  32'h44,        32'h44,        32'h44,        32'h44,        2'b00, 32'h0};

        reset = 1'b0;
        drive(2'b00, 0, 0, '0, '0, 1'b0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        // Reset state on every address, with reset still asserted.
        for (int a = 0; a < NR; a++) begin
            rd_addr[0] = AW'(a);
            rd_addr[1] = AW'(NR - 1 - a);
            #1;
            check_zero($sformatf("reset a%0d", a));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].wen, tbl[i].wa0, tbl[i].wa1, tbl[i].wd0, tbl[i].wd1,
                  tbl[i].rsv, tbl[i].rsva, tbl[i].ra0, tbl[i].ra1);
            #2;
            chk($sformatf("vec%0d byp rd_data[0]", i), b_rd_data[0], tbl[i].b0);
            chk($sformatf("vec%0d byp rd_data[1]", i), b_rd_data[1], tbl[i].b1);
            chk($sformatf("vec%0d nob rd_data[0]", i), n_rd_data[0], tbl[i].n0);
            chk($sformatf("vec%0d nob rd_data[1]", i), n_rd_data[1], tbl[i].n1);
            chk($sformatf("vec%0d byp rd_busy", i), DW'(b_rd_busy), DW'(tbl[i].busy));
            chk($sformatf("vec%0d nob rd_busy", i), DW'(n_rd_busy), DW'(tbl[i].busy));
            chk($sformatf("vec%0d byp busy_vec", i), b_busy_vec, tbl[i].bvec);
            chk($sformatf("vec%0d nob busy_vec", i), n_busy_vec, tbl[i].bvec);
            @(posedge clk);
            #1;
        end

        // Re-synchronise with the model from a known cleared state.
        reset = 1'b0;
        drive(2'b00, 0, 0, '0, '0, 1'b0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();

        // Randomised traffic, addresses biased low to provoke collisions.
        for (int c = 0; c < 400; c++) begin
            logic [AW-1:0] ad [5];
            for (int j = 0; j < 5; j++) begin
                ad[j] = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NR - 1));
            end
            drive(2'($urandom), ad[0], ad[1], DW'($urandom), DW'($urandom),
                  1'($urandom), ad[2], ad[3], ad[4]);
            #2;
            check_model($sformatf("rand%0d", c));
            @(posedge clk);
            model_clock();
            #1;
        end

        // Asynchronous reset in the middle of a cycle with traffic in flight.
        drive(2'b01, 9, 0, 32'hA5A5_A5A5, '0, 1'b1, 9, 9, 9);
        #2;
        check_model("pre-arst setup");
        @(posedge clk);
        model_clock();
        #1;
        drive(2'b11, 9, 4, 32'h1234_5678, 32'h5678_1234, 1'b1, 9, 9, 4);
        #2;
        check_model("pre-arst armed");
        reset = 1'b0;
        #1;
        check_zero("arst immediate");
        @(posedge clk);
        #1;
        check_zero("arst held over edge");
        drive(2'b00, 0, 0, '0, '0, 1'b0, 0, 9, 4);
        reset = 1'b1;
        #2;
        check_zero("arst released");
        model_reset();
        @(posedge clk);
        #1;
        check_model("post-arst cycle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_regbank_mp
